dca_step_sequencer: RTL

DCA_STEP_SEQUENCER -- requirements
Module: dca_step_sequencer

---
 rtl/dca_step_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dca_step_sequencer.sv
// Step sequencer for the DCA datapath: issues MAC steps once operands and store
// credit are available, tracks outstanding stores and signals completion after a drain.
module dca_step_sequencer #(
    parameter int NUM_LOAD_CH = 2,
    parameter int STORE_DEPTH = 3,
    parameter int BW_STEP_CNT = 16,
    localparam int PW = $clog2(STORE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    output logic                   busy,
    input  logic                   inst_valid,
    input  logic                   inst_no_cal,
    input  logic                   inst_load_acc,
    input  logic                   inst_store_req,
    input  logic                   inst_last,
    input  logic [NUM_LOAD_CH-1:0] inst_load_req,
    output logic                   inst_ready,
    input  logic [NUM_LOAD_CH-1:0] load_ready,
    output logic [NUM_LOAD_CH-1:0] load_issue,
    output logic [NUM_LOAD_CH-1:0] load_pop,
    input  logic                   mac_ready,
    input  logic                   mac_done,
    output logic                   mac_start,
    input  logic                   acc_bypass,
    output logic                   acc_pop,
    output logic                   st_push,
    input  logic                   st_done,
    output logic [PW-1:0]          pend_cnt,
    output logic [BW_STEP_CNT-1:0] step_cnt,
    output logic                   complete,
    output logic                   underflow_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [PW-1:0] DEPTH_MAX = PW'(STORE_DEPTH);
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    state_t state;
    state_t state_next;

    logic loads_ok;
    logic store_ok;
    logic issue;
    logic bypass;
    logic step_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue/consume decode; clear suppresses every pulse so it wins over a same-cycle issue.
    always_comb begin
        loads_ok   = &(load_ready | ~inst_load_req);
        store_ok   = ~inst_store_req | (pend_cnt < DEPTH_MAX);
        issue      = (state == IDLE) & enable & inst_valid & ~inst_no_cal & mac_ready
                     & loads_ok & store_ok & ~clear;
        bypass     = (state == IDLE) & inst_valid & inst_no_cal & inst_load_acc
                     & acc_bypass & ~clear;
        step_done  = ((state == EXEC) & mac_done & ~clear) | bypass;

        busy       = (state != IDLE);
        mac_start  = issue;
        load_issue = issue ? inst_load_req : '0;
        inst_ready = step_done;
        load_pop   = step_done ? inst_load_req : '0;
        acc_pop    = step_done & inst_load_acc;
        st_push    = step_done & inst_store_req;
        complete   = (state == DRAIN) & ~clear
                     & ((pend_cnt == '0) | ((pend_cnt == PEND_ONE) & st_done & ~st_push));

        state_next = state;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_next = EXEC;
                end else if (bypass & inst_last) begin
                    state_next = DRAIN;
                end
            end
            EXEC: begin
                if (mac_done) begin
                    state_next = inst_last ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // A simultaneous push and retire cancel, so they cannot raise the underflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt      <= '0;
            underflow_err <= 1'b0;
        end else if (clear) begin
            pend_cnt      <= '0;
            underflow_err <= 1'b0;
        end else begin
            unique case ({st_push, st_done})
                2'b10: begin
                    if (pend_cnt != DEPTH_MAX) begin
                        pend_cnt <= pend_cnt + PEND_ONE;
                    end
                end
                2'b01: begin
                    if (pend_cnt == '0) begin
                        underflow_err <= 1'b1;
                    end else begin
                        pend_cnt <= pend_cnt - PEND_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (clear) begin
            step_cnt <= '0;
        end else if (inst_ready) begin
            step_cnt <= step_cnt + BW_STEP_CNT'(1);
        end
    end

endmodule
